// File: rtl/boot_loader_pkg.sv
// Shared types and widths for the boot-ROM to RAM copy engine.
// Optional readback verify is enabled by defining BOOT_LOADER_VERIFY_EN.
package boot_loader_pkg;

    localparam int unsigned IDX_W  = 16;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COPY   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Address offset that wraps modulo 2^16
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input logic [IDX_W-1:0] off);
        return IDX_W'(base + off);
    endfunction

endpackage

// File: rtl/boot_loader_index.sv
// Word index register for the copy engine: clear, increment and last-word flag.
module boot_loader_index
    import boot_loader_pkg::*;
#(
    parameter int unsigned WORDS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             incr,
    output logic [IDX_W-1:0] idx,
    output logic             is_last
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;

    always_comb begin
        idx_d = idx_q;
        if (clear) begin
            idx_d = '0;
        end else if (incr) begin
            idx_d = IDX_W'(idx_q + IDX_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx     = idx_q;
    assign is_last = (idx_q == LAST_IDX);

endmodule

// File: rtl/boot_loader.sv
// Copies WORDS boot-ROM words into RAM, then selects RAM as the fetch source.
// Define BOOT_LOADER_VERIFY_EN to add a readback compare pass with sticky error.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int unsigned      WORDS    = 16,
    parameter logic [IDX_W-1:0] SRC_BASE = 16'h0000,
    parameter logic [IDX_W-1:0] DST_BASE = 16'h0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [IDX_W-1:0]  brom_address,
    input  logic [DATA_W-1:0] brom_value,
    output logic [IDX_W-1:0]  ram_address,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_is_write,
    input  logic [DATA_W-1:0] ram_value,
    output logic              busy,
    output logic              done,
    output logic              execute_from_ram,
    output logic              error
);

    state_e           state_q;
    state_e           state_d;
    logic             idx_clear;
    logic             idx_incr;
    logic [IDX_W-1:0] idx;
    logic             is_last;
    logic             active;

    boot_loader_index #(
        .WORDS(WORDS)
    ) u_index (
        .clk    (clk),
        .reset  (reset),
        .clear  (idx_clear),
        .incr   (idx_incr),
        .idx    (idx),
        .is_last(is_last)
    );

`ifdef BOOT_LOADER_VERIFY_EN
    logic error_q;
    logic error_d;
`else
    logic unused_ram_value;
    assign unused_ram_value = ^ram_value;
`endif

    // Next-state and index control
    always_comb begin
        state_d   = state_q;
        idx_clear = 1'b0;
        idx_incr  = 1'b0;
`ifdef BOOT_LOADER_VERIFY_EN
        error_d   = error_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_COPY;
                    idx_clear = 1'b1;
`ifdef BOOT_LOADER_VERIFY_EN
                    error_d   = 1'b0;
`endif
                end
            end
            ST_COPY: begin
                if (is_last) begin
                    idx_clear = 1'b1;
`ifdef BOOT_LOADER_VERIFY_EN
                    state_d   = ST_VERIFY;
`else
                    state_d   = ST_DONE;
`endif
                end else begin
                    idx_incr = 1'b1;
                end
            end
`ifdef BOOT_LOADER_VERIFY_EN
            ST_VERIFY: begin
                if (ram_value != brom_value) begin
                    error_d = 1'b1;
                end
                if (is_last) begin
                    state_d = ST_DONE;
                end else begin
                    idx_incr = 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
`ifdef BOOT_LOADER_VERIFY_EN
            error_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
`ifdef BOOT_LOADER_VERIFY_EN
            error_q <= error_d;
`endif
        end
    end

    // Outputs decode from registered state and index only; start never reaches them
    always_comb begin
        active           = (state_q == ST_COPY) || (state_q == ST_VERIFY);
        brom_address     = active ? wrap_add(SRC_BASE, idx) : '0;
        ram_address      = active ? wrap_add(DST_BASE, idx) : '0;
        ram_is_write     = (state_q == ST_COPY);
        ram_in           = ram_is_write ? brom_value : '0;
        busy             = active;
        done             = (state_q == ST_DONE);
        execute_from_ram = done;
`ifdef BOOT_LOADER_VERIFY_EN
        error            = error_q;
`else
        error            = 1'b0;
`endif
    end

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: three differently parameterised copies, stub ROM, modelled RAM.
module tb_boot_loader;

    localparam int NI = 3;
    localparam int RAM_SZ = 65536;
    localparam int unsigned P_WORDS [NI] = '{4, 3, 8};
    localparam logic [15:0] P_SRC [NI] = '{16'h0000, 16'hFFFE, 16'h0000};
    localparam logic [15:0] P_DST [NI] = '{16'h0100, 16'hFFFF, 16'h0200};
    localparam logic [31:0] FILL = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic [NI-1:0]        reset;
    logic [NI-1:0]        start;
    logic [NI-1:0][15:0]  brom_address;
    logic [NI-1:0][31:0]  brom_value;
    logic [NI-1:0][15:0]  ram_address;
    logic [NI-1:0][31:0]  ram_in;
    logic [NI-1:0]        ram_is_write;
    logic [NI-1:0][31:0]  ram_value;
    logic [NI-1:0]        busy;
    logic [NI-1:0]        done;
    logic [NI-1:0]        execute_from_ram;
    logic [NI-1:0]        error;

    logic [31:0] ram_mem [0:NI*RAM_SZ-1];
    logic        corrupt_en = 1'b0;
    logic [15:0] corrupt_addr = 16'h0000;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [1:0]  inst;
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        boot_loader #(
            .WORDS   (P_WORDS[g]),
            .SRC_BASE(P_SRC[g]),
            .DST_BASE(P_DST[g])
        ) u_dut (
            .clk             (clk),
            .reset           (reset[g]),
            .start           (start[g]),
            .brom_address    (brom_address[g]),
            .brom_value      (brom_value[g]),
            .ram_address     (ram_address[g]),
            .ram_in          (ram_in[g]),
            .ram_is_write    (ram_is_write[g]),
            .ram_value       (ram_value[g]),
            .busy            (busy[g]),
            .done            (done[g]),
            .execute_from_ram(execute_from_ram[g]),
            .error           (error[g])
        );
        assign brom_value[g] = {16'hA5A5, brom_address[g]};
        assign ram_value[g]  = ram_mem[g*RAM_SZ + int'(ram_address[g])];
    end

    // RAM: writes on the rising edge; optional single-address data corruption on instance 0
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (ram_is_write[i]) begin
                ram_mem[i*RAM_SZ + int'(ram_address[i])] <=
                    (corrupt_en && i == 0 && ram_address[i] == corrupt_addr) ?
                    (ram_in[i] ^ 32'h0000_0004) : ram_in[i];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every write the DUT issues must match the next expected write
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (ram_is_write[i]) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {16'h0, ram_address[i]}, 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_inst", 32'(i), 32'(e.inst));
                    check("wr_addr", {16'h0, ram_address[i]}, {16'h0, e.addr});
                    check("wr_data", ram_in[i], e.data);
                end
            end
        end
    end

    task automatic push_expected(input int inst, input int n);
        for (int k = 0; k < n; k++) begin
            wr_t e;
            logic [15:0] sa;
            sa     = 16'(P_SRC[inst] + 16'(k));
            e.inst = 2'(inst);
            e.addr = 16'(P_DST[inst] + 16'(k));
            e.data = {16'hA5A5, sa};
            exp_q.push_back(e);
        end
    endtask

    // Start drives high just after edge N; latency is counted in edges after N
    task automatic run_copy(input int inst, input int dup_cyc, output int lat,
                            output int busy_n, output logic err_done, output logic early_ok);
        lat = 0; busy_n = 0; err_done = 1'b0; early_ok = 1'b0;
        @(posedge clk); #1;
        start[inst] = 1'b1;
        push_expected(inst, int'(P_WORDS[inst]));
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            start[inst] = (c == dup_cyc);
            @(negedge clk);
            if (c == 1) early_ok = busy[inst] && !done[inst] && !error[inst];
            if (busy[inst]) busy_n++;
            if (done[inst]) begin
                lat = c;
                err_done = error[inst];
                check("exec_eq_done", {31'h0, execute_from_ram[inst]}, 32'h1);
                break;
            end
        end
        if (lat == 0) $display("FAIL timeout: inst %0d never reached done", inst);
    endtask

    typedef struct {
        int   inst;
        int   dup_cyc;
        int   exp_lat;
        int   exp_busy;
        logic exp_err;
    } vec_t;

    initial begin
        vec_t vecs[4];
        int lat, bn, changed;
        logic ed, eok;

`ifdef BOOT_LOADER_VERIFY_EN
        vecs[0] = '{0, 0, 9, 8, 1'b0};
        vecs[1] = '{1, 0, 7, 6, 1'b0};
        vecs[2] = '{0, 2, 9, 8, 1'b0};
        vecs[3] = '{2, 0, 17, 16, 1'b0};
`else
        vecs[0] = '{0, 0, 5, 4, 1'b0};
        vecs[1] = '{1, 0, 4, 3, 1'b0};
        vecs[2] = '{0, 2, 5, 4, 1'b0};
        vecs[3] = '{2, 0, 9, 8, 1'b0};
`endif
        for (int a = 0; a < NI*RAM_SZ; a++) ram_mem[a] = FILL;
        reset = '1;
        start = '0;
        repeat (3) @(posedge clk);
        #1 reset = '0;

        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check("rst_flags", {27'h0, busy[i], done[i], execute_from_ram[i], ram_is_write[i], error[i]}, 32'h0);
            check("rst_addr", {brom_address[i], ram_address[i]}, 32'h0);
            check("rst_ram_in", ram_in[i], 32'h0);
        end

        // Reset mid-copy: the edge that commits the 3rd write also samples reset
        @(posedge clk); #1;
        start[2] = 1'b1;
        push_expected(2, 3);
        @(posedge clk); #1 start[2] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 reset[2] = 1'b1;
        @(posedge clk); #1 reset[2] = 1'b0;
        @(negedge clk);
        check("rst_mid_flags", {29'h0, busy[2], done[2], ram_is_write[2]}, 32'h0);
        changed = 0;
        for (int a = 0; a < RAM_SZ; a++) if (ram_mem[2*RAM_SZ + a] !== FILL) changed++;
        check("rst_mid_changed", 32'(changed), 32'd3);
        check("rst_mid_sb_empty", 32'(exp_q.size()), 32'd0);

        // Table: basic, wrap, start-during-copy (from DONE), full 8-word run
        foreach (vecs[v]) begin
            run_copy(vecs[v].inst, vecs[v].dup_cyc, lat, bn, ed, eok);
            check("tbl_latency", 32'(lat), 32'(vecs[v].exp_lat));
            check("tbl_busy", 32'(bn), 32'(vecs[v].exp_busy));
            check("tbl_error", {31'h0, ed}, {31'h0, vecs[v].exp_err});
            check("tbl_first_cycle", {31'h0, eok}, 32'h1);
            check("tbl_sb_empty", 32'(exp_q.size()), 32'd0);
            if (v == 0) begin
                for (int k = 0; k < 4; k++)
                    check("basic_ram", ram_mem[16'h0100 + k], 32'hA5A5_0000 + 32'(k));
            end
            if (v == 1) begin
                check("wrap_ram0", ram_mem[RAM_SZ + 16'hFFFF], 32'hA5A5_FFFE);
                check("wrap_ram1", ram_mem[RAM_SZ + 16'h0000], 32'hA5A5_FFFF);
                check("wrap_ram2", ram_mem[RAM_SZ + 16'h0001], 32'hA5A5_0000);
            end
        end

        // Restart from DONE: done must hold until the edge that samples start
        @(posedge clk); #1 start[0] = 1'b1;
        push_expected(0, 4);
        @(negedge clk);
        check("restart_done_held", {31'h0, done[0]}, 32'h1);
        @(posedge clk); #1 start[0] = 1'b0;
        @(negedge clk);
        check("restart_done_fell", {30'h0, done[0], busy[0]}, 32'h1);
        repeat (20) @(negedge clk);
        check("restart_done_again", {31'h0, done[0]}, 32'h1);
        check("restart_sb_empty", 32'(exp_q.size()), 32'd0);

`ifdef BOOT_LOADER_VERIFY_EN
        // Corrupt RAM word 2 on write; verify must flag it, next start clears it
        corrupt_en = 1'b1;
        corrupt_addr = 16'h0102;
        run_copy(0, 0, lat, bn, ed, eok);
        check("vfy_bad_latency", 32'(lat), 32'd9);
        check("vfy_bad_error", {31'h0, ed}, 32'h1);
        corrupt_en = 1'b0;
        run_copy(0, 0, lat, bn, ed, eok);
        check("vfy_clear_early", {31'h0, eok}, 32'h1);
        check("vfy_clean_error", {31'h0, ed}, 32'h0);
        check("vfy_sb_empty", 32'(exp_q.size()), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
